uart_bram_writer: RTL
=====================

UART_BRAM_WRITER -- requirements
Module: uart_bram_writer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2700000 (0.1 s at 27 MHz): max clk cycles allowed between frame bytes.
REQ-002 Parameter ACK_BYTE, default 8'h06: response to an accepted frame.
REQ-003 Parameter NAK_BYTE, default 8'h15: response to a rejected frame.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rx_valid  in  1  one-cycle strobe from UART receiver; rx_data valid this cycle.
REQ-007 rx_data  in  8  received byte.
REQ-008 tx_ready  in  1  UART transmitter can accept a byte.
REQ-009 tx_valid  out  1  response byte offered; held until tx_ready sampled high.
REQ-010 tx_data  out  8  response byte; stable while tx_valid high.
REQ-011 bram_ce  out  1  single-port BRAM clock enable.
REQ-012 bram_wre  out  1  BRAM write enable (1 = write).
REQ-013 bram_ad  out  4  BRAM address (16 x 8 memory).
REQ-014 bram_din  out  8  BRAM write data.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 overrun  out  1  sticky: rx byte arrived while not able to accept it.

Function
REQ-017 Frame, 4 bytes: 8'h57 ('W'), addr, data, csum; csum SHALL equal addr XOR data.
REQ-018 States: IDLE, GET_ADDR, GET_DATA, GET_CSUM, WRITE, RESP.
REQ-019 IDLE: rx_valid with rx_data==8'h57 -> GET_ADDR; any other byte ignored, stay IDLE.
REQ-020 GET_ADDR/GET_DATA: rx_valid latches byte, advances to next state.
REQ-021 GET_CSUM: rx_valid -> WRITE if csum matches and addr[7:4]==0, else RESP with tx_data=NAK_BYTE.
REQ-022 WRITE: exactly one cycle bram_ce=1, bram_wre=1, bram_ad=addr[3:0], bram_din=data; then RESP with tx_data=ACK_BYTE.
REQ-023 Latency: WRITE asserted the cycle after the csum strobe; tx_valid asserted the cycle after WRITE.
REQ-024 RESP: tx_valid=1 until a cycle with tx_ready=1, then tx_valid=0 and -> IDLE next cycle.
REQ-025 bram_wre SHALL be 0 in every state other than WRITE; bram_ce 0 outside WRITE.
REQ-026 Timeout counter resets on every accepted rx byte; in GET_* states reaching TIMEOUT_CYCLES -> IDLE, no response, no write.
REQ-027 Timeout counter held at 0 in IDLE, WRITE, RESP; width ceil(log2(TIMEOUT_CYCLES+1)), no wrap.
REQ-028 rx_valid during WRITE or RESP: byte dropped, overrun set to 1.
REQ-029 overrun cleared only by reset.
REQ-030 Header byte 8'h57 received in GET_* is treated as payload, not a restart.
REQ-031 Write to address 15 followed by address 0 SHALL both succeed; no address auto-increment.

Reset
REQ-032 rst_n low: state IDLE, tx_valid=0, tx_data=0, bram_ce=0, bram_wre=0, bram_ad=0, bram_din=0, busy=0, overrun=0, timeout counter 0.
REQ-033 Reset mid-frame or mid-RESP aborts immediately; no BRAM write issued after rst_n deasserts until a new full frame.

Structure
REQ-034 Shared package holds state enum, ACK/NAK/header constants, default TIMEOUT_CYCLES.
REQ-035 One sub-module natural: interbyte_timer (load/clear, expired flag); rest in one FSM.

Verification
REQ-036 57,03,A5,A6 -> one WRITE cycle ad=3 din=A5, then tx_data=06.
REQ-037 57,03,A5,00 -> no WRITE, tx_data=15.
REQ-038 57,12,44,56 (addr>15) -> no WRITE, tx_data=15.
REQ-039 57,05 then idle TIMEOUT_CYCLES -> IDLE, no tx_valid; then 57,05,01,04 -> write ad=5 din=01, ack.
REQ-040 Valid frame with tx_ready low 100 cycles -> tx_valid/tx_data held 100 cycles; extra rx byte during RESP -> overrun=1.
REQ-041 rst_n pulsed low after GET_DATA byte -> all outputs reset, no write; next full frame works.

Source files
------------

// File: rtl/uart_bram_writer_pkg.sv
// Shared definitions for the UART-to-BRAM frame writer: FSM states, frame
// constants and the frame acceptance rule.
package uart_bram_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CSUM,
    ST_WRITE,
    ST_RESP
  } state_t;

  localparam logic [7:0]  HEADER_BYTE            = 8'h57;
  localparam logic [7:0]  ACK_BYTE_DEFAULT       = 8'h06;
  localparam logic [7:0]  NAK_BYTE_DEFAULT       = 8'h15;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 2700000;

  // Only the low 16 addresses exist, so a frame is accepted only if the
  // checksum matches and the upper address nibble is zero.
  function automatic logic frame_ok(input logic [7:0] addr,
                                    input logic [7:0] data,
                                    input logic [7:0] csum);
    return (csum == (addr ^ data)) && (addr[7:4] == 4'h0);
  endfunction

endpackage

// File: rtl/uart_bram_writer_interbyte_timer.sv
// Inter-byte gap timer: counts idle cycles while a frame is being collected
// and flags expiry once TIMEOUT_CYCLES is reached (saturates, never wraps).
module uart_bram_writer_interbyte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned    CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TC  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  assign expired_o = (cnt_q == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (run_i && !expired_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_bram_writer.sv
// Receives 4-byte 'W' frames from a UART, writes one byte into a 16x8 BRAM
// and answers each completed frame with ACK or NAK.
//
// state    | meaning
// IDLE     | waiting for header byte 8'h57
// GET_ADDR | collecting address byte
// GET_DATA | collecting data byte
// GET_CSUM | collecting checksum byte, then judge frame
// WRITE    | single BRAM write cycle
// RESP     | offering ACK/NAK until tx_ready
module uart_bram_writer
  import uart_bram_writer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       bram_ce,
  output logic       bram_wre,
  output logic [3:0] bram_ad,
  output logic [7:0] bram_din,
  output logic       busy,
  output logic       overrun
);

  state_t     state_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       bram_ce_q;
  logic       bram_wre_q;
  logic [3:0] bram_ad_q;
  logic [7:0] bram_din_q;
  logic       overrun_q;

  logic in_get;
  logic timer_clear;
  logic expired;

  assign in_get      = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA) ||
                       (state_q == ST_GET_CSUM);
  assign timer_clear = !in_get || rx_valid;

  uart_bram_writer_interbyte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (timer_clear),
    .run_i    (in_get),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      bram_ce_q  <= 1'b0;
      bram_wre_q <= 1'b0;
      bram_ad_q  <= '0;
      bram_din_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      bram_ce_q  <= 1'b0;
      bram_wre_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && (rx_data == HEADER_BYTE)) state_q <= ST_GET_ADDR;
        end
        ST_GET_ADDR: begin
          if (expired) begin
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            addr_q  <= rx_data;
            state_q <= ST_GET_DATA;
          end
        end
        ST_GET_DATA: begin
          if (expired) begin
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            data_q  <= rx_data;
            state_q <= ST_GET_CSUM;
          end
        end
        ST_GET_CSUM: begin
          if (expired) begin
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            if (frame_ok(addr_q, data_q, rx_data)) begin
              bram_ce_q  <= 1'b1;
              bram_wre_q <= 1'b1;
              bram_ad_q  <= addr_q[3:0];
              bram_din_q <= data_q;
              state_q    <= ST_WRITE;
            end else begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= NAK_BYTE;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_WRITE: begin
          if (rx_valid) overrun_q <= 1'b1;
          tx_valid_q <= 1'b1;
          tx_data_q  <= ACK_BYTE;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (rx_valid) overrun_q <= 1'b1;
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign bram_ce  = bram_ce_q;
  assign bram_wre = bram_wre_q;
  assign bram_ad  = bram_ad_q;
  assign bram_din = bram_din_q;
  assign busy     = (state_q != ST_IDLE);
  assign overrun  = overrun_q;

endmodule
